// File: rtl/reg_access_pkg.sv
// Shared types and address helpers for the register-file access master.
// The narrow-port address packs {mode, lane, idx}.
package reg_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam int NUM_REGS_DEFAULT = 28;

    localparam int ADDR_IDX_LSB  = 0;
    localparam int ADDR_IDX_MSB  = 4;
    localparam int ADDR_LANE_LSB = 5;
    localparam int ADDR_LANE_MSB = 6;
    localparam int ADDR_MODE_BIT = 7;

    function automatic logic [7:0] make_addr(
        input logic       mode,
        input logic [1:0] lane,
        input logic [4:0] idx
    );
        logic [7:0] addr;
        addr = 8'h00;
        addr[ADDR_IDX_MSB:ADDR_IDX_LSB]   = idx;
        addr[ADDR_LANE_MSB:ADDR_LANE_LSB] = lane;
        addr[ADDR_MODE_BIT]               = mode;
        return addr;
    endfunction

endpackage

// File: rtl/reg_access_master.sv
// Word-level request front end for the register file's narrow port: reads are
// split into 8- or 16-bit slice beats and reassembled, writes are one bus cycle.
module reg_access_master
    import reg_access_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [4:0]  req_idx,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_en,
    output logic        bus_rw,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [15:0] bus_rdata
);

    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);
    localparam logic [1:0] RD_LAT_W   = 2'(RD_LAT);

    state_t      state_r;
    logic [4:0]  idx_r;
    logic        wide_r;
    logic [1:0]  beat_r;
    logic [1:0]  wait_r;
    logic [31:0] asm_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        bus_en_r;
    logic        bus_rw_r;
    logic [7:0]  bus_addr_r;
    logic [31:0] bus_wdata_r;

    logic        idx_err_s;
    logic        last_beat_s;
    logic [1:0]  next_beat_s;
    logic [31:0] asm_next_s;

    // Slice address for a read beat; 16-bit mode only uses the low lane bit.
    function automatic logic [7:0] read_addr(
        input logic       wide,
        input logic [1:0] beat,
        input logic [4:0] idx
    );
        logic [7:0] addr;
        if (wide) begin
            addr = make_addr(1'b1, {1'b0, beat[0]}, idx);
        end else begin
            addr = make_addr(1'b0, beat, idx);
        end
        return addr;
    endfunction

    // Request decode and beat bookkeeping.
    always_comb begin
        idx_err_s   = ({1'b0, req_idx} >= NUM_REGS_W);
        next_beat_s = beat_r + 2'd1;
        if (wide_r) begin
            last_beat_s = (beat_r == 2'd1);
        end else begin
            last_beat_s = (beat_r == 2'd3);
        end
    end

    // Merge the returning slice into the assembly word at the current beat.
    always_comb begin
        asm_next_s = asm_r;
        if (wide_r) begin
            if (beat_r[0]) begin
                asm_next_s[31:16] = bus_rdata;
            end else begin
                asm_next_s[15:0] = bus_rdata;
            end
        end else begin
            case (beat_r)
                2'd0:    asm_next_s[7:0]   = bus_rdata[7:0];
                2'd1:    asm_next_s[15:8]  = bus_rdata[7:0];
                2'd2:    asm_next_s[23:16] = bus_rdata[7:0];
                default: asm_next_s[31:24] = bus_rdata[7:0];
            endcase
        end
    end

    // Transaction FSM; every output is registered and bus fields idle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 5'd0;
            wide_r      <= 1'b0;
            beat_r      <= 2'd0;
            wait_r      <= 2'd0;
            asm_r       <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            bus_en_r    <= 1'b0;
            bus_rw_r    <= 1'b0;
            bus_addr_r  <= 8'd0;
            bus_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_r       <= req_idx;
                        wide_r      <= req_wide;
                        beat_r      <= 2'd0;
                        asm_r       <= 32'd0;
                        req_ready_r <= 1'b0;
                        if (idx_err_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'd0;
                        end else if (req_write) begin
                            state_r     <= ST_WRITE;
                            bus_en_r    <= 1'b1;
                            bus_rw_r    <= 1'b0;
                            bus_addr_r  <= make_addr(1'b0, 2'b00, req_idx);
                            bus_wdata_r <= req_wdata;
                        end else begin
                            state_r     <= ST_RD_ISSUE;
                            bus_en_r    <= 1'b1;
                            bus_rw_r    <= 1'b1;
                            bus_addr_r  <= read_addr(req_wide, 2'd0, req_idx);
                            bus_wdata_r <= 32'd0;
                        end
                    end
                end
                ST_WRITE: begin
                    state_r     <= ST_RESP;
                    bus_en_r    <= 1'b0;
                    bus_rw_r    <= 1'b0;
                    bus_addr_r  <= 8'd0;
                    bus_wdata_r <= 32'd0;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                end
                ST_RD_ISSUE: begin
                    state_r     <= ST_RD_WAIT;
                    wait_r      <= RD_LAT_W;
                    bus_en_r    <= 1'b0;
                    bus_rw_r    <= 1'b0;
                    bus_addr_r  <= 8'd0;
                    bus_wdata_r <= 32'd0;
                end
                ST_RD_WAIT: begin
                    if (wait_r == 2'd1) begin
                        asm_r <= asm_next_s;
                        if (last_beat_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_rdata_r <= asm_next_s;
                        end else begin
                            state_r    <= ST_RD_ISSUE;
                            beat_r     <= next_beat_s;
                            bus_en_r   <= 1'b1;
                            bus_rw_r   <= 1'b1;
                            bus_addr_r <= read_addr(wide_r, next_beat_s, idx_r);
                        end
                    end else begin
                        wait_r <= wait_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    // Response fields stay frozen under backpressure.
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                    bus_en_r    <= 1'b0;
                    bus_rw_r    <= 1'b0;
                    bus_addr_r  <= 8'd0;
                    bus_wdata_r <= 32'd0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign bus_en    = bus_en_r;
    assign bus_rw    = bus_rw_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: vector table plus hand-written
// backpressure and mid-transaction reset sequences against a register-file model.
module tb_reg_access_master;

    localparam int RD_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_wide;
    logic [4:0]  req_idx;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_en;
    logic        bus_rw;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [15:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    reg_access_master #(.NUM_REGS(28), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_wide  (req_wide),
        .req_idx   (req_idx),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_en    (bus_en),
        .bus_rw    (bus_rw),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with one cycle of read latency; upper byte is junk in 8-bit mode.
    logic [31:0] regs [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            regs[0]   <= 32'h0BAD_F00D;
            regs[3]   <= 32'h1122_3344;
            regs[10]  <= 32'h8001_7FFE;
            regs[27]  <= 32'hCAFE_0001;
            bus_rdata <= 16'h0;
        end else if (bus_en && bus_rw) begin
            if (bus_addr[7])
                bus_rdata <= bus_addr[5] ? regs[bus_addr[4:0]][31:16] : regs[bus_addr[4:0]][15:0];
            else
                bus_rdata <= {8'hA5, regs[bus_addr[4:0]][8*bus_addr[6:5] +: 8]};
        end else if (bus_en) begin
            regs[bus_addr[4:0]] <= bus_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int              got_lat;
    int              got_nbus;
    logic [31:0]     got_rdata;
    logic            got_err;
    logic [3:0][7:0] got_addrs;
    logic [31:0]     got_wdata;
    logic            timing_ok;
    logic            idle_ok;
    logic            rw_ok;

    // Handshake one request and observe the bus until the response appears.
    task automatic run_txn(input logic wr, input logic wide, input logic [4:0] idx,
                           input logic [31:0] wdata);
        check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_wide = wide; req_idx = idx; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_write = ~wr; req_wide = ~wide; req_idx = ~idx; req_wdata = ~wdata;
        got_lat = -1; got_nbus = 0; got_addrs = '0; got_wdata = 32'h0;
        got_rdata = 32'hX; got_err = 1'bX;
        timing_ok = 1'b1; idle_ok = 1'b1; rw_ok = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus_en) begin
                if (got_nbus < 4) got_addrs[got_nbus] = bus_addr;
                if (cyc != 1 + got_nbus * (1 + RD_LAT)) timing_ok = 1'b0;
                if (bus_rw == wr) rw_ok = 1'b0;
                got_wdata = bus_wdata;
                got_nbus++;
            end else if (bus_addr != 8'h0 || bus_wdata != 32'h0 || bus_rw) begin
                idle_ok = 1'b0;
            end
            if (rsp_valid) begin
                got_lat = cyc; got_rdata = rsp_rdata; got_err = rsp_err;
                break;
            end
            step();
        end
    endtask

    typedef struct {
        string           name;
        logic            wr;
        logic            wide;
        logic [4:0]      idx;
        logic [31:0]     wdata;
        int              lat;
        logic [31:0]     rdata;
        logic            err;
        int              nbus;
        logic [3:0][7:0] addrs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{"wr_idx5",    1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, 2, 32'h0,          1'b0, 1, 32'h0000_0005};
        vecs[1] = '{"rd8_idx3",   1'b0, 1'b0, 5'd3,  32'h0,         9, 32'h1122_3344,  1'b0, 4, 32'h6343_2303};
        vecs[2] = '{"rd16_idx27", 1'b0, 1'b1, 5'd27, 32'h0,         5, 32'hCAFE_0001,  1'b0, 2, 32'h0000_BB9B};
        vecs[3] = '{"rd8_idx28",  1'b0, 1'b0, 5'd28, 32'h0,         1, 32'h0,          1'b1, 0, 32'h0};
        vecs[4] = '{"wr_idx28",   1'b1, 1'b0, 5'd28, 32'hFFFF_FFFF, 1, 32'h0,          1'b1, 0, 32'h0};
        vecs[5] = '{"rd16_idx31", 1'b0, 1'b1, 5'd31, 32'h0,         1, 32'h0,          1'b1, 0, 32'h0};
        vecs[6] = '{"wr_idx31",   1'b1, 1'b1, 5'd31, 32'h1234_5678, 1, 32'h0,          1'b1, 0, 32'h0};
        vecs[7] = '{"rd8_idx5",   1'b0, 1'b0, 5'd5,  32'h0,         9, 32'hDEAD_BEEF,  1'b0, 4, 32'h6545_2505};
        vecs[8] = '{"rd16_idx10", 1'b0, 1'b1, 5'd10, 32'h0,         5, 32'h8001_7FFE,  1'b0, 2, 32'h0000_AA8A};
        vecs[9] = '{"rd8_idx27",  1'b0, 1'b0, 5'd27, 32'h0,         9, 32'hCAFE_0001,  1'b0, 4, 32'h7B5B_3B1B};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_idx = 5'd0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) step();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst_bus_en",    {31'd0, bus_en}, 32'd0);
        check("rst_bus_rw",    {31'd0, bus_rw}, 32'd0);
        check("rst_bus_addr",  {24'd0, bus_addr}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 10; v++) begin
            run_txn(vecs[v].wr, vecs[v].wide, vecs[v].idx, vecs[v].wdata);
            check({vecs[v].name, "_lat"},   32'(got_lat), 32'(vecs[v].lat));
            check({vecs[v].name, "_rdata"}, got_rdata, vecs[v].rdata);
            check({vecs[v].name, "_err"},   {31'd0, got_err}, {31'd0, vecs[v].err});
            check({vecs[v].name, "_nbus"},  32'(got_nbus), 32'(vecs[v].nbus));
            check({vecs[v].name, "_addrs"}, got_addrs, vecs[v].addrs);
            check({vecs[v].name, "_wdata"}, got_wdata, (vecs[v].wr && !vecs[v].err) ? vecs[v].wdata : 32'h0);
            check({vecs[v].name, "_timing"}, {31'd0, timing_ok}, 32'd1);
            check({vecs[v].name, "_bus_idle"}, {31'd0, idle_ok}, 32'd1);
            check({vecs[v].name, "_bus_rw"}, {31'd0, rw_ok}, 32'd1);
            step();
            check({vecs[v].name, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
        end

        // Backpressure: response must freeze and no new request may be taken.
        rsp_ready = 1'b0;
        run_txn(1'b0, 1'b1, 5'd27, 32'h0);
        check("bp_lat",   32'(got_lat), 32'd5);
        check("bp_rdata", got_rdata, 32'hCAFE_0001);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_idx = 5'd2; req_wdata = 32'h5555_5555;
            step();
            if (!rsp_valid || rsp_rdata != 32'hCAFE_0001 || rsp_err || req_ready || bus_en)
                ok = 1'b0;
        end
        req_valid = 1'b0;
        check("bp_stall_stable", {31'd0, ok}, 32'd1);
        rsp_ready = 1'b1;
        step();
        run_txn(1'b1, 1'b0, 5'd1, 32'h0000_00A1);
        check("bp_next_lat",  32'(got_lat), 32'd2);
        check("bp_next_addr", {24'd0, got_addrs[0]}, 32'h0000_0001);
        check("bp_next_wdata", got_wdata, 32'h0000_00A1);
        step();

        // Reset during beat 2 of an 8-bit read.
        req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_idx = 5'd3;
        step();
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_en && bus_addr == 8'h43) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("rst_mid_beat2_seen", {31'd0, ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus_en",    {31'd0, bus_en}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid || bus_en) ok = 1'b0;
        end
        check("rst_mid_quiet", {31'd0, ok}, 32'd1);
        run_txn(1'b0, 1'b1, 5'd0, 32'h0);
        check("post_rst_lat",   32'(got_lat), 32'd5);
        check("post_rst_rdata", got_rdata, 32'h0BAD_F00D);
        check("post_rst_addrs", {16'd0, got_addrs[1], got_addrs[0]}, 32'h0000_A080);
        check("post_rst_err",   {31'd0, got_err}, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
